sort_frame_ctrl: RTL and testbench
==================================

# sort_frame_ctrl

Frame-level controller that wraps one `Sorting_Stack` instance and runs it as a streaming sorter. It accepts a frame of up to `R_SZ` numbers on a valid/ready input stream and emits the same numbers sorted on a valid/ready output stream. It drives the stack's `hold`/`is_input` controls, counts frame length, and performs the post-reset flush the stack itself lacks. It sits between a producer and a consumer of number frames.

## Interface
- `HBIT`, default 15: MSB index of a number; width is `HBIT+1`.
- `R_SZ`, default 256: maximum frame length, also the stack capacity; must be ≥ 2.
- `ASCEND`, default 0: 0 emits decreasing order, 1 emits increasing order.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset. **Synchronous, active-high.**
- `in_valid` input 1: producer has a number on `in_data`.
- `in_ready` output 1: controller accepts the number this cycle.
- `in_data` input HBIT+1: number to sort.
- `in_last` input 1: qualifies the accepted beat as the last one of the frame.
- `out_valid` output 1: `out_data` holds the next sorted number.
- `out_ready` input 1: consumer takes the number this cycle.
- `out_data` output HBIT+1: sorted number; 0 whenever `out_valid`=0.
- `out_last` output 1: current output beat is the last of the frame.
- `ovf` output 1: one-cycle pulse; the frame was truncated at `R_SZ` beats.
- `busy` output 1: high in CLEAR and DRAIN.

## Operation
- States: CLEAR, LOAD, DRAIN. Length counter `cnt` has width `$clog2(R_SZ+1)`. Clear counter `clr_cnt` has the same width.
- CLEAR is entered on `rst`, which has priority over everything.
  - Stack `hold`=0 and `is_input`=0, so the zero fill flushes the storage. Stack `data_in`=0.
  - `in_ready`=0, `out_valid`=0.
  - `clr_cnt` counts `R_SZ` cycles, counted from the first cycle with `rst`=0, then the state moves to LOAD with `cnt`=0.
  - Holding `rst` high also flushes the stack, but the count restarts when `rst` falls.
- LOAD:
  - `in_ready`=1, stack `is_input`=1, stack `hold`=~`in_valid`, stack `data_in`=`in_data` (bitwise inverted when `ASCEND`=1).
  - Each accepted beat increments `cnt`.
  - On an accepted beat with `in_last`=1, or on the beat that makes `cnt`=`R_SZ`, the state moves to DRAIN.
  - The `R_SZ`-th beat without `in_last` also pulses `ovf` in the same cycle. Further beats form the next frame.
- DRAIN:
  - Stack `is_input`=0, `out_valid`=1, `out_data`=stack `data_out` (inverted when `ASCEND`=1).
  - Stack `hold`=~`out_ready`. Each handshake pops one value and decrements `cnt`.
  - `out_last`=(`cnt`==1). The handshake with `cnt`==1 moves the state to LOAD.
- After a complete drain only the zero fill remains in the stack, so no flush is needed between frames. Zero-valued inputs are legal: the stack is stable, and only `cnt` values are popped.
- Equal keys are all emitted; there is no deduplication.

## Timing
- Reset values (cycle after `rst` is sampled high):
  - `in_ready`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `ovf`=0, `busy`=1.
  - `cnt`=0, `clr_cnt`=0.
- `in_ready` first rises exactly `R_SZ` cycles after the first cycle with `rst`=0.
- Last input beat accepted at edge t → `out_valid`=1 with the extreme value during cycle t+1. This is one cycle of latency; the stack output is combinational once `is_input`=0.
- Throughput: one beat per cycle on each side. Frame turnaround is N load cycles plus N drain cycles, with no extra bubbles.
- The controller never raises `in_ready` and `out_valid` together.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` are held stable.
- `rst` mid-LOAD or mid-DRAIN discards the frame with no output.

## Structure
- Package `sort_frame_pkg` holds:
  - the state enum `sort_state_t` {CLEAR, LOAD, DRAIN};
  - a localparam function for counter width.
- The sole sub-module is `Sorting_Stack #(HBIT,R_SZ)`, instantiated once. `ASCEND` inversion is applied at the controller boundary.
- `ovf` and `out_last` are combinational decodes of state, `cnt` and the handshakes. Everything else is registered.

## Test plan
- **Reset/flush** (`R_SZ`=8): deassert `rst` → `in_ready` stays 0 for exactly 8 cycles, `busy`=1, then `in_ready`=1.
- **Basic sort**: {3,9,1,9,4}, `in_last` on 4, `out_ready`=1 → outputs 9,9,4,3,1 on consecutive cycles, `out_last` on 1, `in_ready`=1 the next cycle.
- **Backpressure**: same frame with `out_ready` toggling 1,0,0,1,… → the sequence is unchanged and `out_data` is stable during stalls. Random `in_valid` gaps during LOAD give identical output.
- **Overflow** (`R_SZ`=8): 10 beats {1..10}, no `in_last` → beats 1–8 accepted, `ovf` pulses on beat 8, outputs 8..1. Beats 9,10 load as the next frame, which ends with `in_last` on 10 → outputs 10,9.
- **Ascending** (`ASCEND`=1, `HBIT`=15): {0,FFFF,7} → outputs 0,7,FFFF.
- **Reset mid-DRAIN** after 2 pops of {6,5,4}: `rst` for 1 cycle → no further outputs, `in_ready` after 8 cycles. Next frame {5,2} → outputs exactly 5,2.

Source files
------------

// File: rtl/sort_frame_pkg.sv
// Shared types and sizing helpers for the streaming frame sorter.
package sort_frame_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    LOAD,
    DRAIN
  } sort_state_t;

  // Width needed to hold a count from 0 up to and including r_sz.
  function automatic int unsigned cnt_width(input int unsigned r_sz);
    return $clog2(r_sz + 1);
  endfunction

endpackage

// File: rtl/sort_frame_ctrl_stack.sv
// Sorting_Stack: R_SZ-deep insertion-sorted register stack, largest value on top.
// Insert (is_input=1): data_in lands in its sorted slot and everything below shifts down.
// Pop (is_input=0): everything shifts up one slot and zero enters at the bottom.
// hold=1 freezes the contents. No reset: the owner flushes it by popping R_SZ times.
module Sorting_Stack #(
  parameter int unsigned HBIT = 15,
  parameter int unsigned R_SZ = 256
) (
  input  logic          clk,
  input  logic          hold,
  input  logic          is_input,
  input  logic [HBIT:0] data_in,
  output logic [HBIT:0] data_out
);

  logic [HBIT:0]   cell_q [R_SZ];
  logic [HBIT:0]   cell_d [R_SZ];
  logic [R_SZ-1:0] gt;

  // Per-slot compare; strict so equal keys keep arrival order above the new one.
  always_comb begin
    gt = '0;
    for (int i = 0; i < R_SZ; i++) begin
      gt[i] = data_in > cell_q[i];
    end
  end

  // Next contents for insert, pop or hold.
  always_comb begin
    for (int i = 0; i < R_SZ; i++) begin
      cell_d[i] = cell_q[i];
    end
    if (!hold) begin
      if (is_input) begin
        if (gt[0]) cell_d[0] = data_in;
        for (int i = 1; i < R_SZ; i++) begin
          // First slot smaller than data_in takes it; slots below take their upper neighbour.
          if (gt[i]) cell_d[i] = gt[i-1] ? cell_q[i-1] : data_in;
        end
      end else begin
        for (int i = 0; i < R_SZ - 1; i++) begin
          cell_d[i] = cell_q[i+1];
        end
        cell_d[R_SZ-1] = '0;
      end
    end
  end

  // Storage register.
  always_ff @(posedge clk) begin
    for (int i = 0; i < R_SZ; i++) begin
      cell_q[i] <= cell_d[i];
    end
  end

  assign data_out = cell_q[0];

endmodule

// File: rtl/sort_frame_ctrl.sv
// sort_frame_ctrl: runs one Sorting_Stack as a valid/ready streaming frame sorter.
// Flushes the stack after reset, loads up to R_SZ beats, then drains them sorted.
module sort_frame_ctrl
  import sort_frame_pkg::*;
#(
  parameter int unsigned HBIT   = 15,
  parameter int unsigned R_SZ   = 256,
  parameter bit          ASCEND = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [HBIT:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [HBIT:0] out_data,
  output logic          out_last,
  output logic          ovf,
  output logic          busy
);

  localparam int unsigned   CW       = cnt_width(R_SZ);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TOP  = CW'(R_SZ - 1);
  // Ascending order is obtained by sorting bitwise-inverted keys in the descending stack.
  localparam logic [HBIT:0] INV_MASK = ASCEND ? '1 : '0;

  sort_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;

  logic          st_hold;
  logic          st_is_input;
  logic [HBIT:0] st_din;
  logic [HBIT:0] st_dout;

  // State and counter registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next-state: flush count, frame length up on load, down on drain.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      CLEAR: begin
        if (clr_cnt_q == CNT_TOP) begin
          state_d   = LOAD;
          cnt_d     = '0;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + CNT_ONE;
        end
      end
      LOAD: begin
        if (in_valid) begin
          cnt_d = cnt_q + CNT_ONE;
          if (in_last || (cnt_q == CNT_TOP)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = LOAD;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Stack controls; reset and CLEAR pop with zero fill to flush old contents.
  always_comb begin
    st_hold     = 1'b0;
    st_is_input = 1'b0;
    st_din      = '0;
    if (!rst) begin
      unique case (state_q)
        LOAD: begin
          st_is_input = 1'b1;
          st_hold     = ~in_valid;
          st_din      = in_data ^ INV_MASK;
        end
        DRAIN: begin
          st_hold = ~out_ready;
        end
        default: ;
      endcase
    end
  end

  // Stream-side decodes of state and count.
  always_comb begin
    in_ready  = (state_q == LOAD);
    out_valid = (state_q == DRAIN);
    busy      = (state_q != LOAD);
    out_data  = out_valid ? (st_dout ^ INV_MASK) : '0;
    out_last  = out_valid && (cnt_q == CNT_ONE);
    ovf       = in_ready && in_valid && !in_last && (cnt_q == CNT_TOP);
  end

  Sorting_Stack #(
    .HBIT(HBIT),
    .R_SZ(R_SZ)
  ) u_stack (
    .clk     (clk),
    .hold    (st_hold),
    .is_input(st_is_input),
    .data_in (st_din),
    .data_out(st_dout)
  );

endmodule

// File: tb/tb_sort_frame_ctrl.sv
// Directed bench for sort_frame_ctrl: a descending and an ascending instance share stimulus.
module tb_sort_frame_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready_d, out_valid_d, out_last_d, ovf_d, busy_d;
  logic [15:0] out_data_d;
  logic        in_ready_a, out_valid_a, out_last_a, ovf_a, busy_a;
  logic [15:0] out_data_a;

  // Selects which instance the checks observe.
  logic        use_a;
  logic        o_in_ready, o_valid, o_last, o_ovf, o_busy;
  logic [15:0] o_data;

  assign o_in_ready = use_a ? in_ready_a  : in_ready_d;
  assign o_valid    = use_a ? out_valid_a : out_valid_d;
  assign o_last     = use_a ? out_last_a  : out_last_d;
  assign o_ovf      = use_a ? ovf_a       : ovf_d;
  assign o_busy     = use_a ? busy_a      : busy_d;
  assign o_data     = use_a ? out_data_a  : out_data_d;

  sort_frame_ctrl #(.HBIT(15), .R_SZ(8), .ASCEND(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_d), .out_ready(out_ready), .out_data(out_data_d),
    .out_last(out_last_d), .ovf(ovf_d), .busy(busy_d)
  );

  sort_frame_ctrl #(.HBIT(15), .R_SZ(8), .ASCEND(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_last(out_last_a), .ovf(ovf_a), .busy(busy_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Frame stimulus and captured results.
  logic [15:0] in_vals [16];
  bit          in_lasts[16];
  int          n_in;
  bit   [7:0]  gap_pat;
  bit   [3:0]  rdy_pat;
  logic [15:0] got_d [32];
  bit          got_l [32];
  int          n_got, cyc, ovf_cnt, ovf_beat, stall_bad;

  task automatic set_frame(input logic [15:0] v0, v1, v2, v3, v4, input int n);
    in_vals[0] = v0; in_vals[1] = v1; in_vals[2] = v2; in_vals[3] = v3; in_vals[4] = v4;
    for (int i = 0; i < 16; i++) in_lasts[i] = 1'b0;
    in_lasts[n-1] = 1'b1;
    n_in = n;
  endtask

  // Drive a frame and collect n_exp output beats; ends just after a rising edge.
  task automatic run_frame(input int n_exp, input int budget);
    int          bi;
    logic        prev_stall;
    logic [15:0] prev_d;
    logic        prev_l;
    bi = 0; cyc = 0; n_got = 0; ovf_cnt = 0; ovf_beat = -1; stall_bad = 0;
    prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
    while (n_got < n_exp && cyc < budget) begin
      in_valid = (bi < n_in) && gap_pat[cyc % 8];
      if (in_valid) begin
        in_data = in_vals[bi];
        in_last = in_lasts[bi];
      end else begin
        in_data = '0;
        in_last = 1'b0;
      end
      out_ready = rdy_pat[cyc % 4];
      @(negedge clk);
      if (prev_stall && o_valid && (o_data !== prev_d || o_last !== prev_l)) stall_bad++;
      prev_stall = o_valid && !out_ready;
      prev_d = o_data;
      prev_l = o_last;
      if (o_ovf) begin
        ovf_cnt++;
        ovf_beat = bi;
      end
      if (o_valid && out_ready && n_got < 32) begin
        got_d[n_got] = o_data;
        got_l[n_got] = o_last;
        n_got++;
      end
      if (in_valid && o_in_ready) bi++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    int busy_bad;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0; use_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    total++; if (o_in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", o_in_ready); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", o_valid); end
    total++; if (o_last !== 1'b0) begin bad++; $display("FAIL rst_out_last: got %b want 0", o_last); end
    total++; if (o_data !== 16'h0) begin bad++; $display("FAIL rst_out_data: got %h want 0", o_data); end
    total++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", o_ovf); end
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL rst_busy: got %b want 1", o_busy); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0; busy_bad = 0;
    while (n < 50) begin
      @(negedge clk);
      if (o_in_ready) break;
      if (o_busy !== 1'b1) busy_bad++;
      n++;
      @(posedge clk);
      #1;
    end
    total++; if (n != 8) begin bad++; $display("FAIL flush_len: got %0d cycles want 8", n); end
    total++; if (busy_bad != 0) begin bad++; $display("FAIL flush_busy: got %0d low cycles want 0", busy_bad); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL load_busy: got %b want 0", o_busy); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_sort();
    logic [15:0] exp_d [5];
    exp_d = '{16'd9, 16'd9, 16'd4, 16'd3, 16'd1};
    use_a = 1'b0;
    set_frame(16'd3, 16'd9, 16'd1, 16'd9, 16'd4, 5);
    gap_pat = 8'hFF; rdy_pat = 4'hF;
    run_frame(5, 60);
    total++; if (n_got != 5) begin bad++; $display("FAIL basic_count: got %0d want 5", n_got); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 4)) begin
        bad++;
        $display("FAIL basic_beat%0d: got %0d/%b want %0d/%b", i, got_d[i], got_l[i], exp_d[i], i == 4);
      end
    end
    total++; if (cyc != 10) begin bad++; $display("FAIL basic_cycles: got %0d want 10", cyc); end
    @(negedge clk);
    total++; if (o_in_ready !== 1'b1 || o_valid !== 1'b0) begin
      bad++; $display("FAIL basic_after: got ready=%b valid=%b want 1/0", o_in_ready, o_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_d [5];
    exp_d = '{16'd9, 16'd9, 16'd4, 16'd3, 16'd1};
    use_a = 1'b0;
    set_frame(16'd3, 16'd9, 16'd1, 16'd9, 16'd4, 5);
    gap_pat = 8'hFF; rdy_pat = 4'b1001;
    run_frame(5, 80);
    total++; if (n_got != 5) begin bad++; $display("FAIL bp_count: got %0d want 5", n_got); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 4)) begin
        bad++;
        $display("FAIL bp_beat%0d: got %0d/%b want %0d/%b", i, got_d[i], got_l[i], exp_d[i], i == 4);
      end
    end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_stable: got %0d changes want 0", stall_bad); end
  endtask

  task automatic test_in_gaps();
    logic [15:0] exp_d [5];
    exp_d = '{16'd9, 16'd9, 16'd4, 16'd3, 16'd1};
    use_a = 1'b0;
    set_frame(16'd3, 16'd9, 16'd1, 16'd9, 16'd4, 5);
    gap_pat = 8'($urandom_range(255)) | 8'h01; rdy_pat = 4'b0111;
    run_frame(5, 120);
    total++; if (n_got != 5) begin bad++; $display("FAIL gap_count: got %0d want 5", n_got); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 4)) begin
        bad++;
        $display("FAIL gap_beat%0d: got %0d/%b want %0d/%b", i, got_d[i], got_l[i], exp_d[i], i == 4);
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_d [10];
    exp_d = '{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd10, 16'd9};
    use_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_vals[i] = 16'(i + 1);
      in_lasts[i] = (i == 9);
    end
    n_in = 10;
    gap_pat = 8'hFF; rdy_pat = 4'hF;
    run_frame(10, 100);
    total++; if (n_got != 10) begin bad++; $display("FAIL ovf_count: got %0d want 10", n_got); end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 7 || i == 9)) begin
        bad++;
        $display("FAIL ovf_beat%0d: got %0d/%b want %0d/%b", i, got_d[i], got_l[i], exp_d[i],
                 i == 7 || i == 9);
      end
    end
    total++; if (ovf_cnt != 1) begin bad++; $display("FAIL ovf_pulses: got %0d want 1", ovf_cnt); end
    total++; if (ovf_beat != 7) begin bad++; $display("FAIL ovf_where: got beat %0d want 7", ovf_beat); end
  endtask

  task automatic test_ascend();
    logic [15:0] exp_d [5];
    use_a = 1'b1;
    set_frame(16'h0000, 16'hFFFF, 16'h0007, 16'h0, 16'h0, 3);
    gap_pat = 8'hFF; rdy_pat = 4'hF;
    exp_d = '{16'h0000, 16'h0007, 16'hFFFF, 16'h0, 16'h0};
    run_frame(3, 40);
    total++; if (n_got != 3) begin bad++; $display("FAIL asc_count: got %0d want 3", n_got); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 2)) begin
        bad++;
        $display("FAIL asc_beat%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], i == 2);
      end
    end
    set_frame(16'd3, 16'd9, 16'd1, 16'd9, 16'd4, 5);
    exp_d = '{16'd1, 16'd3, 16'd4, 16'd9, 16'd9};
    run_frame(5, 40);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (got_d[i] !== exp_d[i]) begin
        bad++; $display("FAIL asc2_beat%0d: got %0d want %0d", i, got_d[i], exp_d[i]);
      end
    end
    use_a = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    int n;
    int stray;
    use_a = 1'b0;
    set_frame(16'd6, 16'd5, 16'd4, 16'd0, 16'd0, 3);
    gap_pat = 8'hFF; rdy_pat = 4'hF;
    run_frame(2, 40);
    total++; if (n_got != 2 || got_d[0] !== 16'd6 || got_d[1] !== 16'd5) begin
      bad++; $display("FAIL mid_pre: got n=%0d %0d,%0d want 2 6,5", n_got, got_d[0], got_d[1]);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    n = 0; stray = 0;
    while (n < 50) begin
      @(negedge clk);
      if (o_in_ready) break;
      if (o_valid) stray++;
      n++;
      @(posedge clk);
      #1;
    end
    total++; if (n != 8) begin bad++; $display("FAIL mid_flush: got %0d cycles want 8", n); end
    total++; if (stray != 0) begin bad++; $display("FAIL mid_stray: got %0d outputs want 0", stray); end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    set_frame(16'd5, 16'd2, 16'd0, 16'd0, 16'd0, 2);
    run_frame(2, 40);
    total++; if (n_got != 2 || got_d[0] !== 16'd5 || got_d[1] !== 16'd2 || got_l[1] !== 1'b1) begin
      bad++; $display("FAIL mid_next: got n=%0d %0d,%0d last=%b want 2 5,2 last=1",
                      n_got, got_d[0], got_d[1], got_l[1]);
    end
    @(negedge clk);
    total++; if (o_valid !== 1'b0 || o_in_ready !== 1'b1) begin
      bad++; $display("FAIL mid_tail: got valid=%b ready=%b want 0/1", o_valid, o_in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic_sort();
    test_backpressure();
    test_in_gaps();
    test_overflow();
    test_ascend();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
